// File: rtl/add32_serial.sv
// add32_serial: multi-cycle adder producing op1 + op2 + cin one CHUNK per clock, LSB chunk first,
// with valid/ready handshakes on the operand and result sides.
module add32_serial #(
    parameter int W     = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op1,
    input  logic [W-1:0] op2,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);
    localparam int NCHUNK = W / CHUNK;
    localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
    localparam logic [IW:0] LAST = (IW + 1)'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [W-1:0]   op1_q, op1_d, op2_q, op2_d, sum_q, sum_d;
    logic           carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic           in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic [CHUNK-1:0] a_c, b_c;
    logic [CHUNK:0]   s_c;
    logic             msb_cin;

    always_comb begin
        a_c         = op1_q[idx_q*CHUNK +: CHUNK];
        b_c         = op2_q[idx_q*CHUNK +: CHUNK];
        s_c         = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, carry_q};
        // carry into the top bit of the chunk, recovered from its sum bit
        msb_cin     = s_c[CHUNK-1] ^ a_c[CHUNK-1] ^ b_c[CHUNK-1];
        state_d     = state_q;
        idx_d       = idx_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    op1_d      = op1;
                    op2_d      = op2;
                    carry_d    = cin;
                    sum_d      = '0;
                    idx_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = BUSY;
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            BUSY: begin
                if ({1'b0, idx_q} > LAST) begin
                    state_d = IDLE;
                end else begin
                    sum_d[idx_q*CHUNK +: CHUNK] = s_c[CHUNK-1:0];
                    carry_d = s_c[CHUNK];
                    idx_d   = idx_q + IW'(1);
                    if ({1'b0, idx_q} == LAST) begin
                        cout_d      = s_c[CHUNK];
                        ovf_d       = msb_cin ^ s_c[CHUNK];
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_add32_serial.sv
// tb_add32_serial: randomized and directed checks of add32_serial against a plain-arithmetic model.
module tb_add32_serial;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          checks = 0;
    int          errors = 0;

    add32_serial dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // One transaction: wait for in_ready, handshake, then check latency, result,
    // hold under backpressure and the release. With noise set, in_valid stays
    // high with garbage operands while the block is busy.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic c,
                          input int hold, input bit noise, input string name);
        logic [32:0] full;
        logic [31:0] es;
        logic        ec, eo;
        int          lat;
        full = {1'b0, a} + {1'b0, b} + {32'd0, c};
        es   = full[31:0];
        ec   = full[32];
        eo   = (a[31] == b[31]) && (es[31] != a[31]);
        for (int i = 0; i < 20 && !in_ready; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s in_ready_timeout got %b exp 1", name, in_ready);
            return;
        end
        op1 = a; op2 = b; cin = c; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = noise;
        op1 = $urandom; op2 = $urandom; cin = 1'($urandom);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s in_ready_after_accept got %b exp 0", name, in_ready);
        end
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            op1 = $urandom; op2 = $urandom;
        end
        checks++;
        if (lat != 4) begin
            errors++;
            $display("FAIL %s latency got %0d exp 4", name, lat);
        end
        checks++;
        if ({sum, cout, ovf} !== {es, ec, eo}) begin
            errors++;
            $display("FAIL %s result got sum=%h cout=%b ovf=%b exp sum=%h cout=%b ovf=%b",
                     name, sum, cout, ovf, es, ec, eo);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({out_valid, in_ready, sum, cout, ovf} !== {1'b1, 1'b0, es, ec, eo}) begin
                errors++;
                $display("FAIL %s hold%0d got v=%b r=%b sum=%h cout=%b ovf=%b exp v=1 r=0 sum=%h",
                         name, i, out_valid, in_ready, sum, cout, ovf, es);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready, sum, cout, ovf} !== {1'b0, 1'b1, es, ec, eo}) begin
            errors++;
            $display("FAIL %s release got v=%b r=%b sum=%h cout=%b ovf=%b exp v=0 r=1 sum=%h",
                     name, out_valid, in_ready, sum, cout, ovf, es);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({in_ready, out_valid, sum, cout, ovf} !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs got r=%b v=%b sum=%h cout=%b ovf=%b exp all 0",
                     in_ready, out_valid, sum, cout, ovf);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_ready got %b exp 0", in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_edge_ready got %b exp 1", in_ready);
        end
    endtask

    task automatic test_directed();
        run_op(32'h00000007, 32'h00000004, 1'b0, 0, 1'b0, "add_basic");
        run_op(32'h00000007, 32'h00000004, 1'b1, 0, 1'b0, "add_cin");
        run_op(32'h000000FF, 32'h00000001, 1'b0, 0, 1'b0, "chunk_carry");
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 0, 1'b0, "unsigned_wrap");
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 0, 1'b0, "signed_ovf");
        run_op(32'h80000000, 32'h80000000, 1'b1, 0, 1'b0, "neg_ovf");
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 0, 1'b0, "all_ones");
    endtask

    task automatic test_backpressure();
        run_op(32'h12345678, 32'h9ABCDEF0, 1'b1, 10, 1'b0, "backpressure");
        run_op(32'h00FF00FF, 32'h00010001, 1'b0, 3, 1'b1, "busy_in_valid_ignored");
    endtask

    task automatic test_reset_busy();
        for (int i = 0; i < 20 && !in_ready; i++) begin
            @(posedge clk); #1;
        end
        op1 = 32'hFFFFFFFF; op2 = 32'h00000001; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, sum, cout, ovf} !== 35'd0) begin
            errors++;
            $display("FAIL reset_busy_outputs got r=%b v=%b sum=%h cout=%b ovf=%b exp all 0",
                     in_ready, out_valid, sum, cout, ovf);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_busy_no_result%0d got %b exp 0", i, out_valid);
            end
        end
        out_ready = 1'b0;
        run_op(32'h80000007, 32'h00000004, 1'b0, 0, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++)
            run_op($urandom, $urandom, 1'($urandom), int'($urandom_range(0, 3)),
                   1'($urandom), "random");
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 6; n++)
            run_op($urandom, $urandom, 1'($urandom), 0, 1'b0, "back_to_back");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_busy();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
